// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core ID/EXE boundary.
// Holds ALU command encodings, NZCV bit indices and the ID/EXE bundle struct.
package arm_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Fixed-width part of the ID/EXE bundle; the DATA_W-wide
    // values (pc, rn, rm) travel beside it in the register.
    typedef struct packed {
        logic [3:0]  exe_cmd;
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
        logic        branch;
        logic        s;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] simm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } id_exe_t;

    localparam id_exe_t ID_EXE_BUBBLE = '0;

endpackage

// File: rtl/id_exe_if.sv
// ID/EXE boundary bundle: decode fields in, registered EXE fields out.
// master = decode/hazard side, slave = the id_exe_reg pipeline register.
interface id_exe_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              hold;
    logic              flush;
    logic              stall;

    logic [3:0]        id_exe_cmd;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_wb_en;
    logic              id_branch;
    logic              id_s;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_val_rn;
    logic [DATA_W-1:0] id_val_rm;
    logic              id_imm;
    logic [11:0]       id_shift_operand;
    logic [23:0]       id_simm24;
    logic [3:0]        id_dest;
    logic [3:0]        id_src1;
    logic [3:0]        id_src2;
    logic [3:0]        alu_nzcv;

    logic [3:0]        exe_exe_cmd;
    logic              exe_mem_read;
    logic              exe_mem_write;
    logic              exe_wb_en;
    logic              exe_branch;
    logic              exe_s;
    logic [DATA_W-1:0] exe_pc;
    logic [DATA_W-1:0] exe_val_rn;
    logic [DATA_W-1:0] exe_val_rm;
    logic              exe_imm;
    logic [11:0]       exe_shift_operand;
    logic [23:0]       exe_simm24;
    logic [3:0]        exe_dest;
    logic [3:0]        exe_src1;
    logic [3:0]        exe_src2;
    logic              exe_valid;
    logic [3:0]        nzcv;
    logic              carry_in;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output hold, flush, stall,
        output id_exe_cmd, id_mem_read, id_mem_write, id_wb_en,
        output id_branch, id_s, id_pc, id_val_rn, id_val_rm,
        output id_imm, id_shift_operand, id_simm24,
        output id_dest, id_src1, id_src2, alu_nzcv,
        input  exe_exe_cmd, exe_mem_read, exe_mem_write, exe_wb_en,
        input  exe_branch, exe_s, exe_pc, exe_val_rn, exe_val_rm,
        input  exe_imm, exe_shift_operand, exe_simm24,
        input  exe_dest, exe_src1, exe_src2,
        input  exe_valid, nzcv, carry_in, bubble_count
    );

    modport slave (
        input  hold, flush, stall,
        input  id_exe_cmd, id_mem_read, id_mem_write, id_wb_en,
        input  id_branch, id_s, id_pc, id_val_rn, id_val_rm,
        input  id_imm, id_shift_operand, id_simm24,
        input  id_dest, id_src1, id_src2, alu_nzcv,
        output exe_exe_cmd, exe_mem_read, exe_mem_write, exe_wb_en,
        output exe_branch, exe_s, exe_pc, exe_val_rn, exe_val_rm,
        output exe_imm, exe_shift_operand, exe_simm24,
        output exe_dest, exe_src1, exe_src2,
        output exe_valid, nzcv, carry_in, bubble_count
    );

endinterface

// File: rtl/id_exe_reg_status_reg.sv
// 4-bit NZCV status register with load enable and async active-high reset.
// Ports: clk, rst, i_ld (load enable), i_d (next flags), o_q (current flags).
module status_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ld,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 4'b0000;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with bubble insertion, hold, NZCV ownership
// and a saturating bubble counter. Ports: clk, rst, bus (id_exe_if.slave).
module id_exe_reg
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic     clk,
    input  logic     rst,
    id_exe_if.slave  bus
);

    id_exe_t           w_id;
    id_exe_t           r_ctl;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rn;
    logic [DATA_W-1:0] r_rm;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_bubble;
    logic              w_flag_ld;
    logic [3:0]        w_nzcv;

    always_comb begin
        w_id               = ID_EXE_BUBBLE;
        w_id.exe_cmd       = bus.id_exe_cmd;
        w_id.mem_read      = bus.id_mem_read;
        w_id.mem_write     = bus.id_mem_write;
        w_id.wb_en         = bus.id_wb_en;
        w_id.branch        = bus.id_branch;
        w_id.s             = bus.id_s;
        w_id.imm           = bus.id_imm;
        w_id.shift_operand = bus.id_shift_operand;
        w_id.simm24        = bus.id_simm24;
        w_id.dest          = bus.id_dest;
        w_id.src1          = bus.id_src1;
        w_id.src2          = bus.id_src2;
    end

    assign w_bubble = bus.flush | bus.stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl   <= ID_EXE_BUBBLE;
            r_pc    <= '0;
            r_rn    <= '0;
            r_rm    <= '0;
            r_valid <= 1'b0;
        end else if (!bus.hold) begin
            if (w_bubble) begin
                r_ctl   <= ID_EXE_BUBBLE;
                r_pc    <= '0;
                r_rn    <= '0;
                r_rm    <= '0;
                r_valid <= 1'b0;
            end else begin
                r_ctl   <= w_id;
                r_pc    <= bus.id_pc;
                r_rn    <= bus.id_val_rn;
                r_rm    <= bus.id_val_rm;
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!bus.hold && w_bubble && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The flag-setting instruction already sits in EXE, so a flush
    // arriving now kills only its successor and the flags still commit.
    assign w_flag_ld = r_ctl.s & r_valid & ~bus.hold;

    status_reg u_status (
        .clk  (clk),
        .rst  (rst),
        .i_ld (w_flag_ld),
        .i_d  (bus.alu_nzcv),
        .o_q  (w_nzcv)
    );

    assign bus.exe_exe_cmd       = r_ctl.exe_cmd;
    assign bus.exe_mem_read      = r_ctl.mem_read;
    assign bus.exe_mem_write     = r_ctl.mem_write;
    assign bus.exe_wb_en         = r_ctl.wb_en;
    assign bus.exe_branch        = r_ctl.branch;
    assign bus.exe_s             = r_ctl.s;
    assign bus.exe_pc            = r_pc;
    assign bus.exe_val_rn        = r_rn;
    assign bus.exe_val_rm        = r_rm;
    assign bus.exe_imm           = r_ctl.imm;
    assign bus.exe_shift_operand = r_ctl.shift_operand;
    assign bus.exe_simm24        = r_ctl.simm24;
    assign bus.exe_dest          = r_ctl.dest;
    assign bus.exe_src1          = r_ctl.src1;
    assign bus.exe_src2          = r_ctl.src2;
    assign bus.exe_valid         = r_valid;
    assign bus.nzcv              = w_nzcv;
    assign bus.carry_in          = w_nzcv[FLAG_C];
    assign bus.bubble_count      = r_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed testbench for id_exe_reg: capture, flags, flush, hold, reset,
// and counter saturation on a second instance with CNT_W=2.
module tb_id_exe_reg;
  import arm_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  id_exe_if #(.DATA_W(32), .CNT_W(16)) bus ();
  id_exe_if #(.DATA_W(32), .CNT_W(2))  bus2 ();

  id_exe_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_exe_reg #(.DATA_W(32), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;

    bus.hold = 0; bus.flush = 0; bus.stall = 0;
    bus.id_exe_cmd = CMD_NOP; bus.id_mem_read = 0;
    bus.id_mem_write = 0; bus.id_wb_en = 0;
    bus.id_branch = 0; bus.id_s = 0; bus.id_pc = '0;
    bus.id_val_rn = '0; bus.id_val_rm = '0; bus.id_imm = 0;
    bus.id_shift_operand = '0; bus.id_simm24 = '0;
    bus.id_dest = '0; bus.id_src1 = '0; bus.id_src2 = '0;
    bus.alu_nzcv = '0;

    bus2.hold = 0; bus2.flush = 0; bus2.stall = 0;
    bus2.id_exe_cmd = CMD_NOP; bus2.id_mem_read = 0;
    bus2.id_mem_write = 0; bus2.id_wb_en = 0;
    bus2.id_branch = 0; bus2.id_s = 0; bus2.id_pc = '0;
    bus2.id_val_rn = '0; bus2.id_val_rm = '0; bus2.id_imm = 0;
    bus2.id_shift_operand = '0; bus2.id_simm24 = '0;
    bus2.id_dest = '0; bus2.id_src1 = '0; bus2.id_src2 = '0;
    bus2.alu_nzcv = '0;

    #2;
    chk("rst_valid", bus.exe_valid, 1'b0);
    chk("rst_nzcv", bus.nzcv, 4'b0000);
    chk("rst_cnt", bus.bubble_count, 16'd0);
    rst = 1'b0;

    bus.id_exe_cmd = CMD_ADD; bus.id_wb_en = 1;
    bus.id_val_rn = 32'd5; bus.id_dest = 4'd3;
    bus.id_pc = 32'h0000_0104;
    tick();
    chk("cap_cmd", bus.exe_exe_cmd, CMD_ADD);
    chk("cap_wb", bus.exe_wb_en, 1'b1);
    chk("cap_rn", bus.exe_val_rn, 32'd5);
    chk("cap_dest", bus.exe_dest, 4'd3);
    chk("cap_pc", bus.exe_pc, 32'h0000_0104);
    chk("cap_valid", bus.exe_valid, 1'b1);

    bus.id_exe_cmd = CMD_SUB; bus.id_s = 1; bus.id_wb_en = 0;
    tick();
    chk("cmp_s", bus.exe_s, 1'b1);
    chk("cmp_nzcv_pre", bus.nzcv, 4'b0000);
    bus.alu_nzcv = 4'b0110;
    bus.id_exe_cmd = CMD_ADD; bus.id_s = 0;
    tick();
    chk("flag_nzcv", bus.nzcv, 4'b0110);
    chk("flag_cin", bus.carry_in, 1'b1);
    bus.alu_nzcv = 4'b1001;
    tick();
    chk("nos_nzcv", bus.nzcv, 4'b0110);

    bus.id_branch = 1; bus.id_exe_cmd = CMD_MOV;
    bus.id_val_rm = 32'hDEAD_BEEF;
    bus.flush = 1;
    tick();
    chk("fl_valid", bus.exe_valid, 1'b0);
    chk("fl_branch", bus.exe_branch, 1'b0);
    chk("fl_cmd", bus.exe_exe_cmd, CMD_NOP);
    chk("fl_rm", bus.exe_val_rm, 32'd0);
    chk("fl_cnt", bus.bubble_count, 16'd1);
    bus.flush = 0;
    tick();
    chk("afl_valid", bus.exe_valid, 1'b1);
    chk("afl_branch", bus.exe_branch, 1'b1);
    chk("afl_rm", bus.exe_val_rm, 32'hDEAD_BEEF);
    chk("afl_cnt", bus.bubble_count, 16'd1);

    bus.id_branch = 0; bus.id_exe_cmd = CMD_SUB; bus.id_s = 1;
    tick();
    bus.alu_nzcv = 4'b1000; bus.flush = 1;
    tick();
    chk("sfl_nzcv", bus.nzcv, 4'b1000);
    chk("sfl_valid", bus.exe_valid, 1'b0);
    chk("sfl_cnt", bus.bubble_count, 16'd2);
    bus.flush = 0;

    bus.id_exe_cmd = CMD_MOV; bus.id_s = 1; bus.id_dest = 4'd7;
    bus.id_val_rm = 32'h55;
    tick();
    bus.hold = 1; bus.flush = 1; bus.stall = 1;
    bus.alu_nzcv = 4'b0001;
    bus.id_exe_cmd = CMD_EOR; bus.id_dest = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_cmd", bus.exe_exe_cmd, CMD_MOV);
      chk("hold_dest", bus.exe_dest, 4'd7);
      chk("hold_valid", bus.exe_valid, 1'b1);
      chk("hold_nzcv", bus.nzcv, 4'b1000);
      chk("hold_cnt", bus.bubble_count, 16'd2);
    end
    bus.hold = 0; bus.stall = 0;
    tick();
    chk("unh_valid", bus.exe_valid, 1'b0);
    chk("unh_cnt", bus.bubble_count, 16'd3);
    chk("unh_nzcv", bus.nzcv, 4'b0001);
    bus.flush = 0;
    tick();
    chk("unh2_cmd", bus.exe_exe_cmd, CMD_EOR);
    chk("unh2_dest", bus.exe_dest, 4'd9);

    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.exe_valid, 1'b0);
    chk("arst_dest", bus.exe_dest, 4'd0);
    chk("arst_nzcv", bus.nzcv, 4'b0000);
    chk("arst_cnt", bus.bubble_count, 16'd0);
    rst = 1'b0;
    tick();
    chk("post_valid", bus.exe_valid, 1'b1);

    chk("sat_start", bus2.bubble_count, 2'd0);
    bus2.stall = 1;
    tick();
    chk("sat_1", bus2.bubble_count, 2'd1);
    tick();
    chk("sat_2", bus2.bubble_count, 2'd2);
    tick();
    chk("sat_3", bus2.bubble_count, 2'd3);
    tick();
    chk("sat_4", bus2.bubble_count, 2'd3);
    tick();
    chk("sat_5", bus2.bubble_count, 2'd3);
    chk("sat_valid", bus2.exe_valid, 1'b0);
    bus2.stall = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

Pipeline register between the Instruction Decode and Execute stages of the 5-stage ARM core. It captures the decoded control word (exe_cmd, mem_read, mem_write, wb_en, branch, status_update) together with the operand and destination fields. It supports bubble insertion for hazards and branch flush, plus a global hold, and it owns the NZCV status register that EXE reads and updates. It also keeps a saturating bubble counter for performance debug.

## Interface
Parameters:
- DATA_W, 32, width of PC and register operand values
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  global freeze (memory wait); all state held
- flush  in  1  branch taken in EXE; kill instruction entering EXE
- stall  in  1  hazard unit request; insert bubble into EXE
- id_exe_cmd  in  4  ALU command from decode
- id_mem_read, id_mem_write, id_wb_en, id_branch, id_s  in  1 each  decode control bits (id_s = status_update)
- id_pc  in  DATA_W  PC+4 of decoded instruction
- id_val_rn, id_val_rm  in  DATA_W  register file read values
- id_imm  in  1  immediate flag
- id_shift_operand  in  12  shifter operand field
- id_simm24  in  24  signed branch offset
- id_dest, id_src1, id_src2  in  4 each  register indices
- alu_nzcv  in  4  flags produced by EXE ALU this cycle {N,Z,C,V}
- exe_* (same names/widths as id_*, prefix exe_)  out  registered copies
- exe_valid  out  1  EXE holds a real instruction
- nzcv  out  4  current status register
- carry_in  out  1  nzcv[1], C flag for ADC/SBC
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Update priority per rising edge: rst > hold > flush > stall > capture.
- rst (async): all exe_* outputs, exe_valid, nzcv, and bubble_count go to 0.
- hold=1: every register, including nzcv and bubble_count, keeps its value regardless of flush/stall.
- flush=1 or stall=1 (hold=0): insert a bubble.
  - exe_exe_cmd=0, exe_mem_read=exe_mem_write=exe_wb_en=exe_branch=exe_s=0, exe_valid=0.
  - All data fields are cleared to 0.
  - bubble_count increments by 1 and saturates at all-ones.
- Otherwise: every exe_* field takes its id_* value and exe_valid<=1.
- Status register:
  - Update condition: exe_s=1 && exe_valid=1 && hold=0. Then nzcv<=alu_nzcv on the same edge the next instruction is captured.
  - The flags of the instruction in EXE are therefore visible to the instruction entering EXE one cycle later.
  - A flush in the same cycle still commits nzcv, because the branching/flagging instruction itself is in EXE and is not killed.
- carry_in is combinational from nzcv; no other combinational paths from inputs to outputs.

## Timing
- Latency: id_* to exe_* is 1 cycle.
- nzcv update is visible 1 cycle after the flag-setting instruction occupies EXE.
- flush and stall are sampled only at the edge. A single-cycle assertion produces exactly one bubble cycle.
- Back-to-back stalls produce consecutive bubbles. bubble_count counts each cycle.
- An asynchronous rst mid-operation takes effect immediately, without waiting for clk. Release of rst is synchronous to the next edge; the first capture happens on the first edge with rst=0.
- flush with hold=1 has no effect that cycle. The branch unit keeps flush asserted until hold drops.

## Structure
- The shared package (arm_pkg) holds:
  - exe_cmd encodings: MOV=0001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000, MVN=1001, NOP=0000.
  - The NZCV bit-index constants (N=3, Z=2, C=1, V=0).
  - A packed struct type for the ID/EXE bundle.
- Sub-module status_reg: a 4-bit NZCV register with load enable and async reset. The pipeline register and bubble counter stay inline.

## Test plan
- Reset: set rst=1 mid-cycle with nonzero contents → all outputs 0 immediately; nzcv=0000, bubble_count=0.
- Capture: id_exe_cmd=0010, id_wb_en=1, id_val_rn=5, id_dest=3 → next edge exe_exe_cmd=0010, exe_wb_en=1, exe_val_rn=5, exe_dest=3, exe_valid=1.
- Flag commit: CMP in EXE (exe_s=1) with alu_nzcv=0110 → next edge nzcv=0110, carry_in=1. Repeat with a non-S instruction → nzcv unchanged.
- Flush: flush=1 for 1 cycle while id_branch=1 is presented → exe_valid=0, all control bits 0, bubble_count=1. The following cycle captures normally.
- Hold precedence: hold=1 with flush=1 and stall=1 for 3 cycles → exe_* and nzcv unchanged and bubble_count unchanged. After hold drops, flush → one bubble.
- Saturation: CNT_W=2, stall held 5 cycles → bubble_count 1,2,3,3,3.
